// File: rtl/dac_spi_rx_monitor.sv
// Receive-side decoder for the 3-wire DAC link: oversamples SYNC/SCLK/DIN, deframes 24-bit writes.
// Optional build macro DAC_RX_COMPARE_EN adds expected_word compare with mismatch pulse/counter.
module dac_spi_rx_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             dataclk,
    input  logic             reset,
    input  logic             DAC_SYNC,
    input  logic             DAC_SCLK,
    input  logic             DAC_DIN,
`ifdef DAC_RX_COMPARE_EN
    input  logic [15:0]      expected_word,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_count,
`endif
    output logic [15:0]      rx_data,
    output logic [1:0]       rx_pd,
    output logic             rx_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sclk_q, din_q;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic                   s_sync, s_sclk, s_din;
    logic                   sclk_prev, sync_prev;
    logic                   fall;

    state_t      state, state_n;
    logic [4:0]  bit_cnt, bit_cnt_n;
    // Only the low 18 bits of a frame are ever used; older bits fall off the end.
    logic [17:0] sr, sr_n, word;
    logic        valid_n, err_n;

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign s_sclk = sclk_q[SYNC_STAGES-1];
    assign s_din  = din_q[SYNC_STAGES-1];
    assign fall   = sclk_prev & ~s_sclk & ~s_sync;
    assign word   = {sr[16:0], s_din};
    assign busy   = (state == SHIFT);

    // vld_pipe marks when the synchronizer holds real samples, so the reset value of
    // SYNC is never mistaken for a genuine high (a frame needs a real high->low).
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            sync_q    <= '1;
            sclk_q    <= '0;
            din_q     <= '0;
            vld_pipe  <= '0;
            sclk_prev <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], DAC_SYNC};
            sclk_q    <= {sclk_q[SYNC_STAGES-2:0], DAC_SCLK};
            din_q     <= {din_q[SYNC_STAGES-2:0], DAC_DIN};
            vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= s_sclk;
            sync_prev <= s_sync & vld_pipe[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        sr_n      = sr;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (sync_prev & ~s_sync) begin
                    state_n   = SHIFT;
                    bit_cnt_n = '0;
                end
            end
            SHIFT: begin
                // SYNC high wins over a coincident fall: the frame aborts.
                if (s_sync) begin
                    err_n   = (bit_cnt != 5'd0);
                    state_n = IDLE;
                end else if (fall) begin
                    sr_n      = word;
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd23) begin
                        valid_n = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (s_sync) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            sr          <= '0;
            rx_data     <= '0;
            rx_pd       <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            sr        <= sr_n;
            rx_valid  <= valid_n;
            frame_err <= err_n;
            if (valid_n) begin
                rx_data     <= word[15:0];
                rx_pd       <= word[17:16];
                frame_count <= frame_count + 1'b1;
            end
            if (err_n && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

`ifdef DAC_RX_COMPARE_EN
    logic mm_n;
    assign mm_n = valid_n && ((word[15:0] != expected_word) || (word[17:16] != 2'b00));

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            mismatch       <= 1'b0;
            mismatch_count <= '0;
        end else begin
            mismatch <= mm_n;
            if (mm_n && (mismatch_count != '1))
                mismatch_count <= mismatch_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_spi_rx_monitor.sv
// Directed bench for dac_spi_rx_monitor: frame-level reference model compared every cycle,
// plus literal expectations per scenario.
module tb_dac_spi_rx_monitor;
    localparam int SS = 2;
    localparam int CW = 16;

    logic          dataclk = 1'b0;
    logic          reset = 1'b1;
    logic          DAC_SYNC = 1'b1, DAC_SCLK = 1'b0, DAC_DIN = 1'b0;
    logic [15:0]   rx_data;
    logic [1:0]    rx_pd;
    logic          rx_valid, frame_err, busy;
    logic [CW-1:0] frame_count, err_count;
`ifdef DAC_RX_COMPARE_EN
    logic [15:0]   expected_word = 16'h8000;
    logic          mismatch;
    logic [CW-1:0] mismatch_count;
`endif

    dac_spi_rx_monitor #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .dataclk(dataclk), .reset(reset),
        .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK), .DAC_DIN(DAC_DIN),
`ifdef DAC_RX_COMPARE_EN
        .expected_word(expected_word), .mismatch(mismatch), .mismatch_count(mismatch_count),
`endif
        .rx_data(rx_data), .rx_pd(rx_pd), .rx_valid(rx_valid), .frame_err(frame_err),
        .frame_count(frame_count), .err_count(err_count), .busy(busy)
    );

    always #5 dataclk = ~dataclk;

    int errors = 0, checks = 0;
    int cyc = 0, fall_cyc = -100, valid_cyc = -1;

    always @(posedge dataclk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the wires as the decoder sees them SS edges late; frame rules applied
    // to whole words held as plain integers.
    logic [2:0]    hist[$];
    int            mode = 0, nbits = 0;
    logic [23:0]   mword = '0;
    logic          m_valid = 0, m_err = 0, m_mm = 0;
    logic [15:0]   m_data = '0;
    logic [1:0]    m_pd = '0;
    logic [CW-1:0] m_fc = '0, m_ec = '0, m_mc = '0;
    logic [2:0]    now_s, prv_s;
    logic          prv_real, m_fall;
    int            t;

    always @(posedge dataclk or posedge reset) begin
        if (reset) begin
            hist.delete();
            mode = 0; nbits = 0; mword = '0;
            m_valid = 0; m_err = 0; m_mm = 0;
            m_data = '0; m_pd = '0; m_fc = '0; m_ec = '0; m_mc = '0;
        end else begin
            hist.push_back({DAC_SYNC, DAC_SCLK, DAC_DIN});
            t        = hist.size();
            now_s    = (t > SS) ? hist[t-1-SS] : 3'b100;
            prv_real = (t > SS + 1);
            prv_s    = prv_real ? hist[t-2-SS] : 3'b000;
            m_fall   = prv_s[1] && !now_s[1] && !now_s[2];
            m_valid  = 0; m_err = 0; m_mm = 0;
            if (mode == 0) begin
                if (prv_real && prv_s[2] && !now_s[2]) begin mode = 1; nbits = 0; mword = '0; end
            end else if (mode == 1) begin
                if (now_s[2]) begin
                    m_err = (nbits > 0);
                    if (m_err && m_ec != {CW{1'b1}}) m_ec = m_ec + 1;
                    mode = 0;
                end else if (m_fall) begin
                    mword = {mword[22:0], now_s[0]};
                    nbits++;
                    if (nbits == 24) begin
                        m_valid = 1; m_data = mword[15:0]; m_pd = mword[17:16];
                        m_fc = m_fc + 1; mode = 2;
`ifdef DAC_RX_COMPARE_EN
                        m_mm = (m_data != expected_word) || (m_pd != 2'b00);
                        if (m_mm && m_mc != {CW{1'b1}}) m_mc = m_mc + 1;
`endif
                    end
                end
            end else if (now_s[2]) begin
                mode = 0;
            end
        end
    end

    always @(negedge dataclk) begin
        if (!reset) begin
            chk("rx_valid", rx_valid, m_valid);
            chk("frame_err", frame_err, m_err);
            chk("rx_data", rx_data, m_data);
            chk("rx_pd", rx_pd, m_pd);
            chk("frame_count", frame_count, m_fc);
            chk("err_count", err_count, m_ec);
            chk("busy", busy, mode == 1);
`ifdef DAC_RX_COMPARE_EN
            chk("mismatch", mismatch, m_mm);
            chk("mismatch_count", mismatch_count, m_mc);
`endif
            if (rx_valid) valid_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge dataclk);
        #1;
    endtask

    // SCLK 4 high / 4 low per bit, DIN set while SCLK high, sampled at the fall.
    // sim_end raises SYNC together with the 24th fall.
    task automatic frame(input logic [23:0] w, input int nfalls, input bit end_sync, input bit sim_end);
        DAC_SYNC = 1'b0;
        tick(3);
        for (int i = 0; i < nfalls; i++) begin
            DAC_DIN  = (i < 24) ? w[23-i] : 1'b0;
            DAC_SCLK = 1'b1;
            tick(4);
            DAC_SCLK = 1'b0;
            if (i == 23) begin
                fall_cyc = cyc + 1;
                if (sim_end) DAC_SYNC = 1'b1;
            end
            tick(4);
        end
        if (end_sync) begin
            DAC_SYNC = 1'b1;
            tick(6);
        end
    endtask

    initial begin
        #23;
        chk("rst_rx_data", rx_data, 16'h0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_frame_count", frame_count, 16'h0);
        chk("rst_busy", busy, 1'b0);
        @(posedge dataclk); #1;
        reset = 1'b0;
        tick(5);

        valid_cyc = -1;
        frame(24'h00A5C3, 24, 1, 0);
        chk("nom_latency", valid_cyc - fall_cyc, 2);
        chk("nom_data", rx_data, 16'hA5C3);
        chk("nom_pd", rx_pd, 2'b00);
        chk("nom_fc", frame_count, 16'd1);

        frame(24'h0, 10, 1, 0);
        chk("abort_ec", err_count, 16'd1);
        chk("abort_keep_data", rx_data, 16'hA5C3);

        frame(24'h03FFFF, 24, 1, 0);
        chk("ffff_data", rx_data, 16'hFFFF);
        chk("ffff_pd", rx_pd, 2'b11);

        frame(24'h001234, 30, 1, 0);
        chk("extra_data", rx_data, 16'h1234);
        chk("extra_fc", frame_count, 16'd3);
        chk("extra_ec", err_count, 16'd1);

        frame(24'h008000, 12, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_data", rx_data, 16'h0);
        chk("arst_fc", frame_count, 16'h0);
        chk("arst_ec", err_count, 16'h0);
        chk("arst_busy", busy, 1'b0);
        tick(2);
        reset = 1'b0;
        frame(24'h00ABCD, 24, 0, 0);
        chk("sync_low_after_rst_fc", frame_count, 16'd0);
        DAC_SYNC = 1'b1;
        tick(6);
        frame(24'h008000, 24, 1, 0);
        chk("post_rst_data", rx_data, 16'h8000);
        chk("post_rst_fc", frame_count, 16'd1);

        frame(24'h00FFFF, 24, 1, 1);
        chk("sim_ec", err_count, 16'd1);
        chk("sim_fc", frame_count, 16'd1);
        chk("sim_data", rx_data, 16'h8000);

        DAC_SYNC = 1'b0;
        tick(10);
        DAC_SYNC = 1'b1;
        tick(6);
        chk("empty_window_ec", err_count, 16'd1);

`ifdef DAC_RX_COMPARE_EN
        frame(24'h008001, 24, 1, 0);
        chk("cmp_mc_1", mismatch_count, 16'd1);
        frame(24'h008000, 24, 1, 0);
        chk("cmp_mc_keep", mismatch_count, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
